// File: rtl/fp_exp_arbiter.sv
// Round-robin arbiter that feeds one shared exponent add/bias-subtract unit.
// Optional macro FP_EXP_ARB_STATS_EN adds grant/stall counters (stat_grants, stat_stalls).
module fp_exp_arbiter #(
    parameter int N_REQ     = 4,
    parameter int ID_W      = 2,
    parameter int EXP_WIDTH = 8,
    parameter int BIAS      = 127
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*EXP_WIDTH-1:0] req_exp_a,
    input  logic [N_REQ*EXP_WIDTH-1:0] req_exp_b,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [ID_W-1:0]            res_id,
    output logic [EXP_WIDTH-1:0]       res_exp,
    output logic                       res_ovf,
    output logic                       res_unf
`ifdef FP_EXP_ARB_STATS_EN
    ,
    output logic [31:0]                stat_grants,
    output logic [31:0]                stat_stalls
`endif
);
    localparam int SW = EXP_WIDTH + 2;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t state_q, state_d;

    logic [N_REQ-1:0][EXP_WIDTH-1:0] exp_a, exp_b;
    assign exp_a = req_exp_a;
    assign exp_b = req_exp_b;

    logic [ID_W-1:0]      rr_ptr, grant_id, rr_next;
    logic                 grant_vld, can_accept, xfer;
    logic [EXP_WIDTH-1:0] a_sel, b_sel, exp_d;
    logic signed [SW-1:0] sum_s;
    logic                 ovf_d, unf_d;
    int                   idx;

    assign res_valid  = (state_q == FULL);
    assign can_accept = !res_valid || res_ready;

    // Scan from rr_ptr with wraparound; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    assign xfer      = grant_vld && can_accept && !rst;
    assign req_ready = xfer ? (N_REQ'(1) << grant_id) : '0;
    assign rr_next   = (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + ID_W'(1);

    // Shared datapath: zero-extended operands, signed result so underflow is visible.
    always_comb begin
        a_sel = exp_a[grant_id];
        b_sel = exp_b[grant_id];
        sum_s = $signed({2'b00, a_sel}) + $signed({2'b00, b_sel}) - $signed(SW'(BIAS));
        ovf_d = (sum_s >= $signed(SW'((1 << EXP_WIDTH) - 1)));
        unf_d = (sum_s <= $signed(SW'(0)));
        exp_d = ovf_d ? '1 : (unf_d ? '0 : sum_s[EXP_WIDTH-1:0]);
    end

    always_comb begin
        state_d = state_q;
        if (xfer)           state_d = FULL;
        else if (res_ready) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            res_id  <= '0;
            res_exp <= '0;
            res_ovf <= 1'b0;
            res_unf <= 1'b0;
        end else if (xfer) begin
            rr_ptr  <= rr_next;
            res_id  <= grant_id;
            res_exp <= exp_d;
            res_ovf <= ovf_d;
            res_unf <= unf_d;
        end
    end

`ifdef FP_EXP_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_grants <= '0;
            stat_stalls <= '0;
        end else begin
            if (xfer)                    stat_grants <= stat_grants + 32'd1;
            if (res_valid && !res_ready) stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fp_exp_arbiter.sv
// Directed + randomized bench for fp_exp_arbiter against a cycle-level reference model.
module tb_fp_exp_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk, rst;
    logic [N-1:0]   req_valid, req_ready;
    logic [N*W-1:0] req_exp_a, req_exp_b;
    logic           res_valid, res_ready;
    logic [1:0]     res_id;
    logic [W-1:0]   res_exp;
    logic           res_ovf, res_unf;
`ifdef FP_EXP_ARB_STATS_EN
    logic [31:0]    stat_grants, stat_stalls;
`endif

    fp_exp_arbiter #(.N_REQ(N), .ID_W(2), .EXP_WIDTH(W), .BIAS(127)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_exp_a(req_exp_a), .req_exp_b(req_exp_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_exp(res_exp), .res_ovf(res_ovf), .res_unf(res_unf)
`ifdef FP_EXP_ARB_STATS_EN
        , .stat_grants(stat_grants), .stat_stalls(stat_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_valid;
    int m_id, m_exp, m_ptr;
    bit m_ovf, m_unf;
    int unsigned m_grants, m_stalls;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input int a, input int b);
        req_exp_a[i*W +: W] = W'(a);
        req_exp_b[i*W +: W] = W'(b);
    endtask

    // One clock: check combinational ready, advance the model, check registered outputs.
    task automatic cycle();
        int g;
        bit can;
        logic [N-1:0] exp_rdy;
        int a, b, s;
        #2;
        can = !m_valid || res_ready;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        exp_rdy = (!rst && can && g >= 0) ? N'(1 << g) : '0;
        chk("req_ready", req_ready, exp_rdy);
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_id = 0; m_exp = 0; m_ovf = 0; m_unf = 0; m_ptr = 0;
            m_grants = 0; m_stalls = 0;
        end else begin
            if (m_valid && !res_ready) m_stalls++;
            if (can && g >= 0) begin
                a = int'(req_exp_a[g*W +: W]);
                b = int'(req_exp_b[g*W +: W]);
                s = a + b - 127;
                m_ovf = (s >= 255);
                m_unf = (s <= 0);
                m_exp = m_ovf ? 255 : (m_unf ? 0 : s);
                m_id = g;
                m_valid = 1;
                m_ptr = (g + 1) % N;
                m_grants++;
            end else if (res_ready) begin
                m_valid = 0;
            end
        end
        #1;
        chk("res_valid", res_valid, m_valid);
        chk("res_id", res_id, m_id);
        chk("res_exp", res_exp, m_exp);
        chk("res_ovf", res_ovf, m_ovf);
        chk("res_unf", res_unf, m_unf);
`ifdef FP_EXP_ARB_STATS_EN
        chk("stat_grants", stat_grants, m_grants);
        chk("stat_stalls", stat_stalls, m_stalls);
`endif
    endtask

    task automatic do_reset();
        rst = 1; req_valid = '0; res_ready = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        int pairs[4][3];
        m_valid = 0; m_id = 0; m_exp = 0; m_ovf = 0; m_unf = 0; m_ptr = 0;
        m_grants = 0; m_stalls = 0;
        req_exp_a = '0; req_exp_b = '0;
        rst = 1; req_valid = '0; res_ready = 1;
        cycle();
        cycle();
        rst = 0;

        // Single request on lane 0
        set_lane(0, 130, 127);
        req_valid = 4'b0001;
        cycle();
        chk("single_exp", res_exp, 130);
        chk("single_id", res_id, 0);

        // Saturation corners, value then flags {ovf,unf}
        pairs = '{'{200, 200, 255}, '{60, 67, 0}, '{127, 1, 1}, '{254, 127, 254}};
        for (int p = 0; p < 4; p++) begin
            do_reset();
            set_lane(0, pairs[p][0], pairs[p][1]);
            req_valid = 4'b0001;
            cycle();
            chk("sat_exp", res_exp, pairs[p][2]);
            chk("sat_flags", {res_ovf, res_unf}, (p == 0) ? 2'b10 : (p == 1) ? 2'b01 : 2'b00);
        end

        // Round robin with all requesters valid
        do_reset();
        for (int i = 0; i < N; i++) set_lane(i, 100 + i, 100);
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            cycle();
            chk("rr_id", res_id, k % N);
            chk("rr_exp", res_exp, 73 + (k % N));
        end

        // Backpressure: hold FULL three cycles with 0110 pending
        do_reset();
        req_valid = 4'b0001;
        cycle();
        res_ready = 0; req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold_id", res_id, 0);
        end
        res_ready = 1;
        #2;
        chk("bp_release_ready", req_ready, 4'b0010);
        cycle();
        chk("bp_new_id", res_id, 1);

        // Reset while FULL with everybody requesting
        req_valid = 4'b1111; res_ready = 0;
        cycle();
        rst = 1;
        #2;
        chk("rst_ready", req_ready, 4'b0000);
        cycle();
        chk("rst_valid", res_valid, 0);
        rst = 0; res_ready = 1;
        cycle();
        chk("post_rst_id", res_id, 0);

`ifdef FP_EXP_ARB_STATS_EN
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 5; k++) cycle();
        req_valid = '0; res_ready = 0;
        cycle(); cycle();
        chk("stats_grants5", stat_grants, 5);
        chk("stats_stalls2", stat_stalls, 2);
        rst = 1;
        cycle();
        chk("stats_clr", {stat_grants, stat_stalls}, 64'd0);
        rst = 0; res_ready = 1;
`endif

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++) set_lane(i, $urandom_range(255), $urandom_range(255));
            req_valid = N'($urandom);
            res_ready = ($urandom_range(9) < 7);
            rst = ($urandom_range(49) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
